// File: rtl/pipe_issue_ctrl_pkg.sv
// Shared types, default sizes and function-code decode helpers for the in-order issue controller.
package pipe_ctrl_pkg;

  localparam int DEF_REG_AW = 4;
  localparam int DEF_FUNC_W = 4;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_WB_LAT = 3;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [DEF_FUNC_W-1:0] {
    FN_ADD   = 4'd0,
    FN_SUB   = 4'd1,
    FN_MUL   = 4'd2,
    FN_PASSA = 4'd3,
    FN_PASSB = 4'd4,
    FN_AND   = 4'd5,
    FN_OR    = 4'd6,
    FN_XOR   = 4'd7,
    FN_NEGA  = 4'd8,
    FN_NEGB  = 4'd9,
    FN_SHR1  = 4'd10,
    FN_SHL2  = 4'd11
  } func_e;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } ctrl_state_e;

  function automatic logic func_legal(input logic [DEF_FUNC_W-1:0] f);
    return (f <= FN_SHL2);
  endfunction

  // Illegal codes read no operands, so they can never be held back by a hazard.
  function automatic logic uses_rs1(input logic [DEF_FUNC_W-1:0] f);
    case (func_e'(f))
      FN_ADD, FN_SUB, FN_MUL, FN_PASSA, FN_AND, FN_OR, FN_XOR,
      FN_NEGA, FN_SHR1, FN_SHL2: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [DEF_FUNC_W-1:0] f);
    case (func_e'(f))
      FN_ADD, FN_SUB, FN_MUL, FN_PASSB, FN_AND, FN_OR, FN_XOR,
      FN_NEGB: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_issue_ctrl_scoreboard.sv
// In-flight destination tracker: a WB_LAT-deep {valid,rd} shift register with
// a read-after-write compare against the sources the incoming op actually uses.
module pipe_scoreboard
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW,
  parameter int WB_LAT = DEF_WB_LAT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_alloc,
  input  logic [REG_AW-1:0] i_alloc_rd,
  input  logic [REG_AW-1:0] i_rs1,
  input  logic [REG_AW-1:0] i_rs2,
  input  logic              i_use_rs1,
  input  logic              i_use_rs2,
  output logic              o_hazard,
  output logic              o_any_valid
);

  logic [WB_LAT-1:0] r_vld;
  logic [REG_AW-1:0] r_rd [WB_LAT];
  logic              w_hazard;

  // Slot 0 mirrors the issue register; every slot advances one step per cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld <= '0;
      for (int i = 0; i < WB_LAT; i++) begin
        r_rd[i] <= '0;
      end
    end else begin
      r_vld[0] <= i_alloc;
      r_rd[0]  <= i_alloc_rd;
      for (int i = 1; i < WB_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_rd[i]  <= r_rd[i-1];
      end
    end
  end

  // Hazard when any live slot targets a source register the op will read.
  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < WB_LAT; i++) begin
      w_hazard = w_hazard | (r_vld[i] & ((i_use_rs1 & (r_rd[i] == i_rs1)) |
                                         (i_use_rs2 & (r_rd[i] == i_rs2))));
    end
  end

  assign o_hazard    = w_hazard;
  assign o_any_valid = |r_vld;

endmodule

// File: rtl/pipe_issue_ctrl.sv
// In-order issue controller: RUN/DRAIN FSM, issue register, illegal-op drop and
// saturating issue/stall counters around the hazard scoreboard.
module pipe_issue_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW,
  parameter int FUNC_W = DEF_FUNC_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int WB_LAT = DEF_WB_LAT,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [REG_AW-1:0] i_in_rs1,
  input  logic [REG_AW-1:0] i_in_rs2,
  input  logic [REG_AW-1:0] i_in_rd,
  input  logic [FUNC_W-1:0] i_in_func,
  input  logic [ADDR_W-1:0] i_in_addr,
  input  logic              i_drain_req,
  output logic              o_iss_valid,
  output logic [REG_AW-1:0] o_iss_rs1,
  output logic [REG_AW-1:0] o_iss_rs2,
  output logic [REG_AW-1:0] o_iss_rd,
  output logic [FUNC_W-1:0] o_iss_func,
  output logic [ADDR_W-1:0] o_iss_addr,
  output logic              o_busy,
  output logic              o_drained,
  output logic              o_illegal,
  output logic [CNT_W-1:0]  o_issue_cnt,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  ctrl_state_e       r_state;
  logic              r_drained;
  logic              r_illegal;
  logic              r_iss_valid;
  logic [REG_AW-1:0] r_iss_rs1;
  logic [REG_AW-1:0] r_iss_rs2;
  logic [REG_AW-1:0] r_iss_rd;
  logic [FUNC_W-1:0] r_iss_func;
  logic [ADDR_W-1:0] r_iss_addr;
  logic [CNT_W-1:0]  r_issue_cnt;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_run, w_legal, w_use_rs1, w_use_rs2, w_hazard, w_any_valid;
  logic w_hs, w_issue, w_drop;

  assign w_run      = (r_state == RUN);
  assign w_legal    = func_legal(i_in_func);
  assign w_use_rs1  = uses_rs1(i_in_func);
  assign w_use_rs2  = uses_rs2(i_in_func);
  assign o_in_ready = w_run & ~w_hazard;
  assign w_hs       = i_in_valid & o_in_ready;
  assign w_issue    = w_hs & w_legal;
  assign w_drop     = w_hs & ~w_legal;

  pipe_scoreboard #(
    .REG_AW (REG_AW),
    .WB_LAT (WB_LAT)
  ) u_scoreboard (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_alloc     (w_issue),
    .i_alloc_rd  (i_in_rd),
    .i_rs1       (i_in_rs1),
    .i_rs2       (i_in_rs2),
    .i_use_rs1   (w_use_rs1),
    .i_use_rs2   (w_use_rs2),
    .o_hazard    (w_hazard),
    .o_any_valid (w_any_valid)
  );

  // Run/drain control; drained pulses in the first RUN cycle after an empty DRAIN.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= RUN;
      r_drained <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          r_drained <= 1'b0;
          if (i_drain_req) begin
            r_state <= DRAIN;
          end else begin
            r_state <= RUN;
          end
        end
        DRAIN: begin
          if (!w_any_valid) begin
            r_state   <= RUN;
            r_drained <= 1'b1;
          end else begin
            r_state   <= DRAIN;
            r_drained <= 1'b0;
          end
        end
        default: begin
          r_state   <= RUN;
          r_drained <= 1'b0;
        end
      endcase
    end
  end

  // Issue register, illegal-drop pulse and saturating performance counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_iss_valid <= 1'b0;
      r_illegal   <= 1'b0;
      r_iss_rs1   <= '0;
      r_iss_rs2   <= '0;
      r_iss_rd    <= '0;
      r_iss_func  <= '0;
      r_iss_addr  <= '0;
      r_issue_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_iss_valid <= w_issue;
      r_illegal   <= w_drop;
      if (w_issue) begin
        r_iss_rs1  <= i_in_rs1;
        r_iss_rs2  <= i_in_rs2;
        r_iss_rd   <= i_in_rd;
        r_iss_func <= i_in_func;
        r_iss_addr <= i_in_addr;
      end
      if (w_issue && (r_issue_cnt != '1)) begin
        r_issue_cnt <= r_issue_cnt + CNT_ONE;
      end
      if (w_run && i_in_valid && w_hazard && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
    end
  end

  assign o_busy      = w_any_valid | (r_state == DRAIN);
  assign o_drained   = r_drained;
  assign o_illegal   = r_illegal;
  assign o_iss_valid = r_iss_valid;
  assign o_iss_rs1   = r_iss_rs1;
  assign o_iss_rs2   = r_iss_rs2;
  assign o_iss_rd    = r_iss_rd;
  assign o_iss_func  = r_iss_func;
  assign o_iss_addr  = r_iss_addr;
  assign o_issue_cnt = r_issue_cnt;
  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Bench for pipe_issue_ctrl: directed scenarios plus random traffic, all checked
// against a register-ready-time reference model.
module tb_pipe_issue_ctrl;

  localparam int WB_LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, drain_req;
  logic [3:0]  in_rs1, in_rs2, in_rd, in_func;
  logic [7:0]  in_addr;
  logic        iss_valid, busy, drained, illegal;
  logic [3:0]  iss_rs1, iss_rs2, iss_rd, iss_func;
  logic [7:0]  iss_addr;
  logic [15:0] issue_cnt, stall_cnt;

  always #5 clk = ~clk;

  pipe_issue_ctrl dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_rs1    (in_rs1),
    .i_in_rs2    (in_rs2),
    .i_in_rd     (in_rd),
    .i_in_func   (in_func),
    .i_in_addr   (in_addr),
    .i_drain_req (drain_req),
    .o_iss_valid (iss_valid),
    .o_iss_rs1   (iss_rs1),
    .o_iss_rs2   (iss_rs2),
    .o_iss_rd    (iss_rd),
    .o_iss_func  (iss_func),
    .o_iss_addr  (iss_addr),
    .o_busy      (busy),
    .o_drained   (drained),
    .o_illegal   (illegal),
    .o_issue_cnt (issue_cnt),
    .o_stall_cnt (stall_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a register is readable from the cycle stored in free_at.
  int  cyc = 0;
  int  free_at [16];
  int  last_alloc = -100;
  bit  m_drain = 1'b0;
  bit  e_iss_valid, e_illegal, e_drained;
  int  e_rs1, e_rs2, e_rd, e_func, e_addr;
  int  e_issue, e_stall;
  int  accepts = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit m_uses1(input int f);
    return f inside {0, 1, 2, 3, 5, 6, 7, 8, 10, 11};
  endfunction

  function automatic bit m_uses2(input int f);
    return f inside {0, 1, 2, 4, 5, 6, 7, 9};
  endfunction

  task automatic model_reset();
    foreach (free_at[i]) free_at[i] = 0;
    last_alloc  = -100;
    m_drain     = 1'b0;
    e_iss_valid = 1'b0; e_illegal = 1'b0; e_drained = 1'b0;
    e_rs1 = 0; e_rs2 = 0; e_rd = 0; e_func = 0; e_addr = 0;
    e_issue = 0; e_stall = 0;
  endtask

  // One clock: drive, check combinational outputs before the edge, step model, check registers.
  task automatic run_cycle(input bit r, input bit v, input int rs1, input int rs2,
                           input int rd, input int fn, input int ad, input bit dr);
    bit haz, exp_ready, exp_busy, hs;
    rst = r; in_valid = v; drain_req = dr;
    in_rs1 = 4'(rs1); in_rs2 = 4'(rs2); in_rd = 4'(rd); in_func = 4'(fn); in_addr = 8'(ad);
    #8;
    haz = (m_uses1(fn) && cyc < free_at[rs1]) || (m_uses2(fn) && cyc < free_at[rs2]);
    exp_ready = !m_drain && !haz;
    exp_busy  = m_drain || (cyc <= last_alloc + WB_LAT);
    check_eq("in_ready", 32'(in_ready), 32'(exp_ready));
    check_eq("busy", 32'(busy), 32'(exp_busy));
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      hs = v && exp_ready;
      e_iss_valid = hs && (fn <= 11);
      e_illegal   = hs && (fn > 11);
      if (hs) accepts++;
      if (e_iss_valid) begin
        e_rs1 = rs1; e_rs2 = rs2; e_rd = rd; e_func = fn; e_addr = ad;
        free_at[rd] = cyc + WB_LAT + 1;
        if (e_issue < 65535) e_issue++;
      end
      if (!m_drain && v && haz && e_stall < 65535) e_stall++;
      e_drained = 1'b0;
      if (!m_drain) begin
        if (dr) m_drain = 1'b1;
      end else if (cyc > last_alloc + WB_LAT) begin
        m_drain   = 1'b0;
        e_drained = 1'b1;
      end
      if (e_iss_valid) last_alloc = cyc;
    end
    cyc++;
    #1;
    check_eq("iss_valid", 32'(iss_valid), 32'(e_iss_valid));
    check_eq("iss_rs1", 32'(iss_rs1), 32'(e_rs1));
    check_eq("iss_rs2", 32'(iss_rs2), 32'(e_rs2));
    check_eq("iss_rd", 32'(iss_rd), 32'(e_rd));
    check_eq("iss_func", 32'(iss_func), 32'(e_func));
    check_eq("iss_addr", 32'(iss_addr), 32'(e_addr));
    check_eq("illegal", 32'(illegal), 32'(e_illegal));
    check_eq("drained", 32'(drained), 32'(e_drained));
    check_eq("issue_cnt", 32'(issue_cnt), 32'(e_issue));
    check_eq("stall_cnt", 32'(stall_cnt), 32'(e_stall));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) run_cycle(1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b0);
  endtask

  initial begin
    int a0;
    model_reset();
    rst = 1'b1; in_valid = 1'b0; drain_req = 1'b0;
    in_rs1 = 4'd0; in_rs2 = 4'd0; in_rd = 4'd0; in_func = 4'd0; in_addr = 8'd0;
    @(posedge clk); #1;
    run_cycle(1'b1, 1'b0, 0, 0, 0, 0, 0, 1'b0);
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_issue_cnt", 32'(issue_cnt), 32'd0);

    // Independent ADDs back to back.
    run_cycle(1'b0, 1'b1, 2, 3, 1, 0, 8'h10, 1'b0);
    run_cycle(1'b0, 1'b1, 5, 6, 4, 0, 8'h11, 1'b0);
    check_eq("t1_iss_rd", 32'(iss_rd), 32'd4);
    idle(4);
    check_eq("t1_stall", 32'(stall_cnt), 32'd0);
    check_eq("t1_issue", 32'(issue_cnt), 32'd2);

    // RAW: SUB r7=r1-r2 behind ADD r1 waits three cycles.
    run_cycle(1'b1, 1'b0, 0, 0, 0, 0, 0, 1'b0);
    run_cycle(1'b0, 1'b1, 2, 3, 1, 0, 8'h20, 1'b0);
    a0 = accepts;
    for (int k = 0; k < 4; k++) run_cycle(1'b0, 1'b1, 1, 2, 7, 1, 8'h21, 1'b0);
    check_eq("t2_accepts", 32'(accepts - a0), 32'd1);
    check_eq("t2_stall", 32'(stall_cnt), 32'd3);
    check_eq("t2_issue", 32'(issue_cnt), 32'd2);

    // PASSB ignores rs1, so no stall on r1.
    run_cycle(1'b0, 1'b1, 2, 3, 1, 0, 8'h30, 1'b0);
    run_cycle(1'b0, 1'b1, 1, 5, 9, 4, 8'h31, 1'b0);
    check_eq("t3_iss_valid", 32'(iss_valid), 32'd1);
    check_eq("t3_stall", 32'(stall_cnt), 32'd3);

    // Illegal func is consumed and dropped.
    run_cycle(1'b0, 1'b1, 0, 0, 3, 13, 8'h40, 1'b0);
    check_eq("t4_illegal", 32'(illegal), 32'd1);
    check_eq("t4_iss_valid", 32'(iss_valid), 32'd0);

    // Drain with two ops in flight, then again with an empty scoreboard.
    idle(4);
    run_cycle(1'b0, 1'b1, 0, 0, 2, 3, 8'h50, 1'b0);
    run_cycle(1'b0, 1'b1, 0, 0, 3, 3, 8'h51, 1'b1);
    idle(6);
    run_cycle(1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b1);
    idle(3);

    // Reset with three ops in flight and a drain pending.
    for (int k = 0; k < 3; k++) run_cycle(1'b0, 1'b1, 0, 0, 10 + k, 3, k, 1'b0);
    run_cycle(1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b1);
    run_cycle(1'b1, 1'b0, 0, 0, 0, 0, 0, 1'b0);
    check_eq("t6_busy", 32'(busy), 32'd0);
    check_eq("t6_drained", 32'(drained), 32'd0);
    idle(5);

    // Random traffic over a small register set to provoke hazards.
    for (int k = 0; k < 3000; k++) begin
      run_cycle($urandom_range(0, 299) == 0,
                $urandom_range(0, 3) != 0,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 255)),
                $urandom_range(0, 24) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
